basemul_acc: RTL and testbench

- Downstream consumer of the basemul stage in the NTT-domain matrix-vector product.
- Accumulates basemul output pairs (r[0], r[1]) for one pair index across K polynomial products: the sum over j of A[i][j] times s[j].
- Emits the accumulated pair, reduced mod q, during the final pass.
- Output feeds the inverse-NTT input buffer.

---
 rtl/basemul_acc.sv | 209 ++++++++++++++++++++
 tb/tb_basemul_acc.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/basemul_acc.sv
// rtl/basemul_acc.sv - accumulates basemul result pairs across K products and emits reduced pairs
//
// Purpose:
//   Sums basemul output pairs (r[0], r[1]) for each pair index i over K
//   polynomial products (poly-major arrival order) and, during the final
//   pass, emits acc[i] + input (reduced mod q = 3329) toward the inverse-NTT buffer.
//   Optional feature macro BASEMUL_ACC_REDUCE_EN: when defined, outputs are
//   canonical in [0, q-1]; when undefined, outputs are the raw signed sum
//   truncated to `KYBER_POLY_WIDTH bits.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               single-cycle pulse, begins a K-pass accumulation (ignored while busy)
//   in_valid/in_ready   input handshake for in_r0/in_r1 (signed basemul pair)
//   out_valid/out_ready output handshake for out_r0/out_r1/out_idx
//   busy                accumulation in progress
//   done                one-cycle pulse after the last output pair is consumed

`ifndef KYBER_K
`define KYBER_K 3
`endif
`ifndef KYBER_POLY_WIDTH
`define KYBER_POLY_WIDTH 16
`endif

module basemul_acc #(
  parameter int K       = `KYBER_K,
  parameter int N_PAIRS = 128,
  parameter int ACC_W   = `KYBER_POLY_WIDTH + 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic signed [`KYBER_POLY_WIDTH-1:0] in_r0,
  input  logic signed [`KYBER_POLY_WIDTH-1:0] in_r1,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [`KYBER_POLY_WIDTH-1:0] out_r0,
  output logic signed [`KYBER_POLY_WIDTH-1:0] out_r1,
  output logic [6:0]                          out_idx,
  output logic                                busy,
  output logic                                done
);

  localparam int PW  = `KYBER_POLY_WIDTH;
  localparam int IW  = $clog2(N_PAIRS);
  localparam int PIW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FINAL, S_DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           pair_idx_q, pair_idx_d;
  logic [PIW-1:0]          poly_idx_q, poly_idx_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [PW-1:0]    out_r0_q, out_r0_d;
  logic signed [PW-1:0]    out_r1_q, out_r1_d;
  logic [6:0]              out_idx_q, out_idx_d;
  logic                    done_q, done_d;

  // Accumulator storage; deliberately not reset, pass 0 overwrites every entry.
  logic signed [ACC_W-1:0] acc_q [N_PAIRS][2];
  logic                    acc_we;

  logic signed [ACC_W-1:0] in_ext0, in_ext1;
  logic signed [ACC_W-1:0] sum0, sum1;
  logic signed [PW-1:0]    res0, res1;

  assign in_ext0 = {{(ACC_W-PW){in_r0[PW-1]}}, in_r0};
  assign in_ext1 = {{(ACC_W-PW){in_r1[PW-1]}}, in_r1};

  // Product 0 ignores whatever is stored (stale data from a previous or
  // abandoned operation); this also covers K==1 where FINAL is pass 0.
  assign sum0 = (poly_idx_q == '0) ? in_ext0 : acc_q[pair_idx_q][0] + in_ext0;
  assign sum1 = (poly_idx_q == '0) ? in_ext1 : acc_q[pair_idx_q][1] + in_ext1;

`ifdef BASEMUL_ACC_REDUCE_EN
  localparam int RW = ACC_W + 16;
  localparam logic signed [RW-1:0] BARRETT_M = RW'(20159);  // round(2^26 / 3329)
  localparam logic signed [RW-1:0] Q_S       = RW'(3329);

  // Barrett quotient estimate (floor) leaves r within one q of the canonical
  // range for |v| < 2^(ACC_W-1); a single conditional correction finishes it.
  function automatic logic signed [PW-1:0] reduce_q(input logic signed [ACC_W-1:0] v);
    logic signed [RW-1:0] vx, t, r;
    vx = {{(RW-ACC_W){v[ACC_W-1]}}, v};
    t  = (vx * BARRETT_M) >>> 26;
    r  = vx - t * Q_S;
    if (r < 0) begin
      r = r + Q_S;
    end else if (r >= Q_S) begin
      r = r - Q_S;
    end
    return r[PW-1:0];
  endfunction

  assign res0 = reduce_q(sum0);
  assign res1 = reduce_q(sum1);
`else
  assign res0 = sum0[PW-1:0];
  assign res1 = sum1[PW-1:0];
`endif

  always_comb begin
    state_d     = state_q;
    pair_idx_d  = pair_idx_q;
    poly_idx_d  = poly_idx_q;
    out_valid_d = out_valid_q;
    out_r0_d    = out_r0_q;
    out_r1_d    = out_r1_q;
    out_idx_d   = out_idx_q;
    done_d      = 1'b0;
    acc_we      = 1'b0;
    in_ready    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = (K == 1) ? S_FINAL : S_ACCUM;
          pair_idx_d = '0;
          poly_idx_d = '0;
        end
      end

      S_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_we = 1'b1;
          if (pair_idx_q == IW'(N_PAIRS - 1)) begin
            pair_idx_d = '0;
            poly_idx_d = poly_idx_q + PIW'(1);
            if (poly_idx_q + PIW'(1) == PIW'(K - 1)) begin
              state_d = S_FINAL;
            end
          end else begin
            pair_idx_d = pair_idx_q + IW'(1);
          end
        end
      end

      S_FINAL: begin
        // A consume and an accept on the same edge replace the held pair.
        in_ready = !out_valid_q || out_ready;
        if (in_valid && in_ready) begin
          out_valid_d = 1'b1;
          out_r0_d    = res0;
          out_r1_d    = res1;
          out_idx_d   = 7'(pair_idx_q);
          if (pair_idx_q == IW'(N_PAIRS - 1)) begin
            pair_idx_d = '0;
            state_d    = S_DRAIN;
          end else begin
            pair_idx_d = pair_idx_q + IW'(1);
          end
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end
      end

      S_DRAIN: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          done_d      = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pair_idx_q  <= '0;
      poly_idx_q  <= '0;
      out_valid_q <= 1'b0;
      out_r0_q    <= '0;
      out_r1_q    <= '0;
      out_idx_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pair_idx_q  <= pair_idx_d;
      poly_idx_q  <= poly_idx_d;
      out_valid_q <= out_valid_d;
      out_r0_q    <= out_r0_d;
      out_r1_q    <= out_r1_d;
      out_idx_q   <= out_idx_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && acc_we) begin
      acc_q[pair_idx_q][0] <= sum0;
      acc_q[pair_idx_q][1] <= sum1;
    end
  end

  assign out_valid = out_valid_q;
  assign out_r0    = out_r0_q;
  assign out_r1    = out_r1_q;
  assign out_idx   = out_idx_q;
  assign done      = done_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_basemul_acc.sv
// tb/tb_basemul_acc.sv - directed self-checking bench for basemul_acc (K=3, 128 pairs)

`ifndef KYBER_POLY_WIDTH
`define KYBER_POLY_WIDTH 16
`endif

module tb_basemul_acc;

  localparam int PW = `KYBER_POLY_WIDTH;
  localparam int NP = 128;
  localparam int NA = 3 * NP;

`ifdef BASEMUL_ACC_REDUCE_EN
  localparam int T2_R0 = 671,    T2_R1 = 3314;
  localparam int T3_R0 = 3,      T3_R1 = 3326;
  localparam int T4_R1_10 = 3299, T4_R1_127 = 2948;
`else
  localparam int T2_R0 = 4000,   T2_R1 = -15;
  localparam int T3_R0 = -19971, T3_R1 = 19971;
  localparam int T4_R1_10 = -30,  T4_R1_127 = -381;
`endif

  logic                 clk, rst_n, start, in_valid, in_ready;
  logic signed [PW-1:0] in_r0, in_r1;
  logic                 out_valid, out_ready;
  logic signed [PW-1:0] out_r0, out_r1;
  logic [6:0]           out_idx;
  logic                 busy, done;

  basemul_acc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r0     (in_r0),
    .in_r1     (in_r1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r0    (out_r0),
    .out_r1    (out_r1),
    .out_idx   (out_idx),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int r0_base [3];
  int r1_base [3];
  int r0_k, r1_k, bp_pair, bp_len, restart_at;
  int n_acc, n_out, n_done, idx_err, val_err, bp_err, n_stall, timeouts;
  int got_r0 [NP];
  int got_r1 [NP];
  int cons_cyc [NP];

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_val(input int sum);
    logic signed [PW-1:0] t;
`ifdef BASEMUL_ACC_REDUCE_EN
    t = PW'(((sum % 3329) + 3329) % 3329);
`else
    t = PW'(sum);
`endif
    return int'(t);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one full operation: pulses start, keeps in_valid high throughout
  // (so any accept outside ACCUM/FINAL shows up as n_acc > 384), collects
  // outputs and counts done pulses.
  task automatic run_op();
    int cyc, bp_cnt, j, extra, sum0, sum1;
    logic done_seen, restarted, acc_now;
    logic signed [PW-1:0] h0, h1;
    logic [6:0] hidx;
    n_acc = 0; n_out = 0; n_done = 0; idx_err = 0; val_err = 0; bp_err = 0; n_stall = 0;
    h0 = '0; h1 = '0; hidx = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0; extra = 0; bp_cnt = 0; done_seen = 1'b0; restarted = 1'b0;
    while (cyc < 3000 && !(done_seen && extra >= 3)) begin
      if (done_seen) extra++;
      j = (n_acc / NP > 2) ? 2 : n_acc / NP;
      in_valid = 1'b1;
      in_r0 = PW'(r0_base[j] + r0_k * (n_acc % NP));
      in_r1 = PW'(r1_base[j] + r1_k * (n_acc % NP));
      start = (restart_at >= 0 && n_acc == restart_at && !restarted);
      if (start) restarted = 1'b1;
      out_ready = 1'b1;
      if (out_valid && out_idx == 7'(bp_pair) && bp_cnt < bp_len) begin
        out_ready = 1'b0;
        if (bp_cnt == 0) begin
          h0 = out_r0; h1 = out_r1; hidx = out_idx;
        end
        bp_cnt++;
        n_stall++;
      end
      #1;
      if (!out_ready) begin
        if (in_ready !== 1'b0 || out_r0 !== h0 || out_r1 !== h1 || out_idx !== hidx || out_valid !== 1'b1)
          bp_err++;
      end
      acc_now = in_valid && in_ready;
      if (out_valid && out_ready) begin
        if (n_out < NP) begin
          if (out_idx !== 7'(n_out)) idx_err++;
          got_r0[n_out] = int'(out_r0);
          got_r1[n_out] = int'(out_r1);
          cons_cyc[n_out] = cyc;
        end
        n_out++;
      end
      if (done === 1'b1) begin
        n_done++;
        done_seen = 1'b1;
      end
      @(posedge clk);
      #1;
      if (acc_now) n_acc++;
      cyc++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    if (cyc >= 3000) timeouts++;
    for (int k = 0; k < NP; k++) begin
      sum0 = 0; sum1 = 0;
      for (int p = 0; p < 3; p++) begin
        sum0 += r0_base[p] + r0_k * k;
        sum1 += r1_base[p] + r1_k * k;
      end
      if (k >= n_out || got_r0[k] !== exp_val(sum0) || got_r1[k] !== exp_val(sum1)) val_err++;
    end
  endtask

  task automatic op_checks(input string t);
    chk({t, "_accepts"}, n_acc, NA);
    chk({t, "_outputs"}, n_out, NP);
    chk({t, "_idx_order_err"}, idx_err, 0);
    chk({t, "_value_err"}, val_err, 0);
    chk({t, "_done_pulses"}, n_done, 1);
    chk({t, "_busy_after"}, int'(busy), 0);
  endtask

  initial begin
    int dcnt;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_r0 = '0; in_r1 = '0;
    r0_k = 0; r1_k = 0; bp_pair = -1; bp_len = 0; restart_at = -1; timeouts = 0;
    repeat (3) tick();

    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_out_r0", int'(out_r0), 0);
    chk("rst_out_r1", int'(out_r1), 0);
    chk("rst_out_idx", int'(out_idx), 0);

    // Abandon an operation after 50 accepts of stale data.
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("accum_busy", int'(busy), 1);
    chk("accum_in_ready", int'(in_ready), 1);
    in_valid = 1'b1; in_r0 = PW'(777); in_r1 = PW'(-777);
    repeat (50) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    in_valid = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    dcnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (done !== 1'b0) dcnt++;
      tick();
    end
    chk("midrst_no_done", dcnt, 0);

    // T1: all ones -> (3,3) everywhere; stale 777 must be overwritten.
    r0_base = '{1, 1, 1}; r1_base = '{1, 1, 1};
    run_op();
    op_checks("t1");
    chk("t1_r0_first", got_r0[0], 3);
    chk("t1_r1_49", got_r1[49], 3);

    // T2: 1000/2000/1000 and -5.
    r0_base = '{1000, 2000, 1000}; r1_base = '{-5, -5, -5};
    run_op();
    op_checks("t2");
    chk("t2_r0_0", got_r0[0], T2_R0);
    chk("t2_r1_0", got_r1[0], T2_R1);
    chk("t2_r0_127", got_r0[127], T2_R0);

    // T3: negative boundary.
    r0_base = '{-6657, -6657, -6657}; r1_base = '{6657, 6657, 6657};
    run_op();
    op_checks("t3");
    chk("t3_r0_0", got_r0[0], T3_R0);
    chk("t3_r1_64", got_r1[64], T3_R1);

    // T4: in_valid held in IDLE, start pulsed mid-ACCUM, stall at pair 10.
    dcnt = 0;
    in_valid = 1'b1; in_r0 = PW'(5); in_r1 = PW'(5);
    for (int c = 0; c < 4; c++) begin
      #1;
      if (in_ready !== 1'b0 || busy !== 1'b0) dcnt++;
      tick();
    end
    chk("idle_no_accept", dcnt, 0);
    r0_base = '{0, 0, 0}; r1_base = '{0, 0, 0}; r0_k = 1; r1_k = -1;
    bp_pair = 10; bp_len = 5; restart_at = 200;
    run_op();
    op_checks("t4");
    chk("t4_stall_cycles", n_stall, 5);
    chk("t4_stall_hold_err", bp_err, 0);
    chk("t4_b2b_10_11", cons_cyc[11] - cons_cyc[10], 1);
    chk("t4_r0_10", got_r0[10], 30);
    chk("t4_r1_10", got_r1[10], T4_R1_10);
    chk("t4_r0_127", got_r0[127], 381);
    chk("t4_r1_127", got_r1[127], T4_R1_127);

    chk("timeouts", timeouts, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
